// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: BCD HH:MM 24-hour time-of-day counter with NUM_ALARMS
// independent alarm channels. Each channel has its own alarm time, ring
// duration, daily re-arm, snooze and dismiss. The front-panel register
// interface drives the set_* inputs. Alarm/alarm_active feed the buzzer and
// indicator drivers.
module multi_alarm_clock #(
  parameter int TICKS_PER_MIN = 60000,
  parameter int NUM_ALARMS    = 4,
  parameter int SEL_W         = 2,
  parameter int DUR_W         = 4,
  parameter int SNOOZE_MIN    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           set_Clock,
  input  logic [15:0]           set_Alarm,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic [DUR_W-1:0]      dur_Alarm,
  input  logic                  off_Alarm,
  input  logic                  snooze,
  output logic [15:0]           Clock,
  output logic                  Alarm,
  output logic [NUM_ALARMS-1:0] alarm_active,
  output logic                  min_tick
);

  localparam int TW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [TW-1:0]    TICK_LAST   = TW'(TICKS_PER_MIN - 1);
  localparam logic [DUR_W-1:0] SNOOZE_LOAD = DUR_W'(SNOOZE_MIN);
  localparam logic [DUR_W-1:0] ONE_MIN     = DUR_W'(1);

  // Per-channel states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_RINGING = 2'd2;
  localparam logic [1:0] ST_SNOOZED = 2'd3;

  // A 14-bit BCD HH:MM value is legal when hours are 00-23 and minutes 00-59.
  function automatic logic f_validTime(input logic [13:0] t);
    logic hoursOk;
    logic minsOk;
    if (t[13:12] < 2'd2) hoursOk = (t[11:8] <= 4'd9);
    else                 hoursOk = (t[13:12] == 2'd2) && (t[11:8] <= 4'd3);
    minsOk = (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    return hoursOk && minsOk;
  endfunction

  logic [15:0]                      r_clock;
  logic [TW-1:0]                    r_tick;
  logic                             r_minTick;
  logic [NUM_ALARMS-1:0][1:0]       r_state;
  logic [NUM_ALARMS-1:0][13:0]      r_time;
  logic [NUM_ALARMS-1:0][DUR_W-1:0] r_dur;
  logic [NUM_ALARMS-1:0][DUR_W-1:0] r_rem;
  logic [NUM_ALARMS-1:0][DUR_W-1:0] r_snz;

  logic                  w_loadClock;
  logic                  w_termCount;
  logic                  w_minTick;
  logic                  w_timeEvent;
  logic                  w_alarmTimeOk;
  logic [15:0]           w_clockInc;
  logic [15:0]           w_clockNext;
  logic [NUM_ALARMS-1:0] w_wrHit;

  // A zero load is treated as "no load", so 00:00 can only come from reset
  // or rollover. The top two bits must be clear for a legal HH:MM value.
  assign w_loadClock   = (set_Clock != 16'h0000) && (set_Clock[15:14] == 2'b00)
                         && f_validTime(set_Clock[13:0]);
  assign w_termCount   = (r_tick == TICK_LAST);
  // A load in the terminal-count cycle swallows that minute's rollover.
  assign w_minTick     = w_termCount && !w_loadClock;
  assign w_timeEvent   = w_loadClock || w_minTick;
  assign w_alarmTimeOk = f_validTime(set_Alarm[13:0]);

  // The clock value one minute ahead, with BCD carries and the 23:59 wrap.
  always_comb begin
    w_clockInc = r_clock;
    if (r_clock[3:0] != 4'd9) begin
      w_clockInc[3:0] = r_clock[3:0] + 4'd1;
    end else begin
      w_clockInc[3:0] = 4'd0;
      if (r_clock[7:4] != 4'd5) begin
        w_clockInc[7:4] = r_clock[7:4] + 4'd1;
      end else begin
        w_clockInc[7:4] = 4'd0;
        if (r_clock[13:8] == 6'h23) begin
          w_clockInc[15:8] = 8'h00;
        end else if (r_clock[11:8] == 4'd9) begin
          w_clockInc[11:8]  = 4'd0;
          w_clockInc[13:12] = r_clock[13:12] + 2'd1;
        end else begin
          w_clockInc[11:8] = r_clock[11:8] + 4'd1;
        end
      end
    end
  end

  // Alarm matching looks at this value so a channel starts ringing on the
  // same edge at which Clock shows its alarm time.
  assign w_clockNext = w_loadClock ? set_Clock
                     : (w_minTick ? w_clockInc : r_clock);

  // Time-of-day register, minute prescaler and the registered minute pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clock   <= 16'h0000;
      r_tick    <= '0;
      r_minTick <= 1'b0;
    end else begin
      r_clock   <= w_clockNext;
      r_minTick <= w_minTick;
      if (w_loadClock || w_termCount) r_tick <= '0;
      else                            r_tick <= r_tick + TW'(1);
    end
  end

  // Decode which channel a set_Alarm write targets. Out-of-range selects
  // match no channel and are dropped.
  always_comb begin
    w_wrHit = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      w_wrHit[i] = set_Alarm[15] && (alarm_sel == SEL_W'(i));
    end
  end

  // Channel FSMs. A write to a channel overrides dismiss, snooze and match
  // for that channel in the same cycle. Dismiss beats snooze. Rings and
  // snoozes count whole minutes off the shared rollover strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= '0;
      r_time  <= '0;
      r_dur   <= '0;
      r_rem   <= '0;
      r_snz   <= '0;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (w_wrHit[i]) begin
          r_time[i]  <= set_Alarm[13:0];
          r_dur[i]   <= dur_Alarm;
          r_rem[i]   <= '0;
          r_snz[i]   <= '0;
          r_state[i] <= (set_Alarm[14] && w_alarmTimeOk) ? ST_ARMED : ST_IDLE;
        end else begin
          case (r_state[i])
            ST_ARMED: begin
              if (w_timeEvent && (w_clockNext[13:0] == r_time[i])) begin
                r_state[i] <= ST_RINGING;
                r_rem[i]   <= r_dur[i];
              end
            end
            ST_RINGING: begin
              if (off_Alarm) begin
                r_state[i] <= ST_ARMED;
              end else if (snooze) begin
                r_state[i] <= ST_SNOOZED;
                r_snz[i]   <= SNOOZE_LOAD;
              end else if (w_minTick && (r_dur[i] != '0)) begin
                if (r_rem[i] <= ONE_MIN) r_state[i] <= ST_ARMED;
                else                     r_rem[i]   <= r_rem[i] - ONE_MIN;
              end
            end
            ST_SNOOZED: begin
              if (off_Alarm) begin
                r_state[i] <= ST_ARMED;
              end else if (w_minTick) begin
                if (r_snz[i] <= ONE_MIN) begin
                  r_state[i] <= ST_RINGING;
                  r_rem[i]   <= r_dur[i];
                end else begin
                  r_snz[i] <= r_snz[i] - ONE_MIN;
                end
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  // Ringing indicators are pure decodes of the registered channel states.
  always_comb begin
    alarm_active = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      alarm_active[i] = (r_state[i] == ST_RINGING);
    end
  end

  assign Alarm    = |alarm_active;
  assign Clock    = r_clock;
  assign min_tick = r_minTick;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Testbench for multi_alarm_clock with a 10-cycle minute. Expected per-minute
// observations are queued as each scenario is set up and are popped and
// compared as the DUT's Clock advances.
module tb_multi_alarm_clock;

  localparam int TPM = 10;
  localparam int NA  = 4;
  localparam int SW  = 2;
  localparam int DW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   set_Clock;
  logic [15:0]   set_Alarm;
  logic [SW-1:0] alarm_sel;
  logic [DW-1:0] dur_Alarm;
  logic          off_Alarm;
  logic          snooze;
  logic [15:0]   Clock;
  logic          Alarm;
  logic [NA-1:0] alarm_active;
  logic          min_tick;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    logic [15:0]   clockVal;
    logic          alarm;
    logic [NA-1:0] active;
  } exp_t;

  exp_t sbq[$];

  multi_alarm_clock #(
    .TICKS_PER_MIN(TPM),
    .NUM_ALARMS(NA),
    .SEL_W(SW),
    .DUR_W(DW),
    .SNOOZE_MIN(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .set_Clock(set_Clock),
    .set_Alarm(set_Alarm),
    .alarm_sel(alarm_sel),
    .dur_Alarm(dur_Alarm),
    .off_Alarm(off_Alarm),
    .snooze(snooze),
    .Clock(Clock),
    .Alarm(Alarm),
    .alarm_active(alarm_active),
    .min_tick(min_tick)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Reference time model: minutes-of-day arithmetic, converted back to BCD
  function automatic logic [15:0] bcdAdd(input logic [15:0] t, input int n);
    int mins;
    int h;
    int m;
    mins = (int'(t[13:12]) * 10 + int'(t[11:8])) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
    mins = (mins + n) % 1440;
    h = mins / 60;
    m = mins % 60;
    return {2'b00, 2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until Clock changes, bounded to two minutes of cycles
  task automatic waitMinute(output int cycles, output bit timedOut);
    logic [15:0] prev;
    prev = Clock;
    cycles = 0;
    timedOut = 1'b1;
    for (int k = 0; k < 2 * TPM; k++) begin
      tick();
      cycles++;
      if (Clock !== prev) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic loadClock(input logic [15:0] v);
    set_Clock = v;
    tick();
    set_Clock = 16'h0000;
  endtask

  task automatic writeAlarm(input int ch, input logic arm, input logic [13:0] t, input logic [DW-1:0] dur);
    set_Alarm = {1'b1, arm, t};
    alarm_sel = SW'(ch);
    dur_Alarm = dur;
    tick();
    set_Alarm = 16'h0000;
    alarm_sel = '0;
    dur_Alarm = '0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    nChecks++;
    if (Clock !== 16'h0000 || Alarm !== 1'b0 || alarm_active !== 4'b0000 || min_tick !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL reset_outputs: got clock=%h alarm=%b active=%b tick=%b, expected 0000/0/0000/0",
               Clock, Alarm, alarm_active, min_tick);
    end
    reset = 1'b0;
    tick();
    nChecks++;
    if (Clock !== 16'h0000 || min_tick !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL after_release: got clock=%h tick=%b, expected 0000/0", Clock, min_tick);
    end
  endtask

  task automatic test_single_ring();
    exp_t e;
    int cy;
    bit to;
    logic a;
    loadClock(16'h1232);
    nChecks++;
    if (Clock !== 16'h1232 || min_tick !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL load_1232: got clock=%h tick=%b, expected 1232/0", Clock, min_tick);
    end
    writeAlarm(0, 1'b1, 14'h1308, 4'd8);
    for (int n = 1; n <= 45; n++) begin
      a = (n >= 36) && (n < 44);
      sbq.push_back(exp_t'{clockVal: bcdAdd(16'h1232, n), alarm: a, active: {3'b000, a}});
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      waitMinute(cy, to);
      nChecks++;
      if (to || Clock !== e.clockVal || Alarm !== e.alarm || alarm_active !== e.active || min_tick !== 1'b1) begin
        nErrors++;
        $display("[TB] FAIL single_ring: got clock=%h alarm=%b active=%b tick=%b timeout=%0b, expected clock=%h alarm=%b active=%b tick=1",
                 Clock, Alarm, alarm_active, min_tick, to, e.clockVal, e.alarm, e.active);
      end
    end
    // The channel must still be armed: it rings again at the same time.
    loadClock(16'h1307);
    waitMinute(cy, to);
    nChecks++;
    if (to || Clock !== 16'h1308 || alarm_active !== 4'b0001) begin
      nErrors++;
      $display("[TB] FAIL rearm_ch0: got clock=%h active=%b, expected clock=1308 active=0001", Clock, alarm_active);
    end
    writeAlarm(0, 1'b0, 14'h0000, 4'd0);
    nChecks++;
    if (Alarm !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL disarm_ch0: got alarm=%b, expected 0", Alarm);
    end
  endtask

  task automatic test_rollover();
    exp_t e;
    int cy;
    bit to;
    loadClock(16'h2358);
    nChecks++;
    if (Clock !== 16'h2358 || min_tick !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL load_2358: got clock=%h tick=%b, expected 2358/0", Clock, min_tick);
    end
    sbq.push_back(exp_t'{clockVal: 16'h2359, alarm: 1'b0, active: 4'b0000});
    sbq.push_back(exp_t'{clockVal: 16'h0000, alarm: 1'b0, active: 4'b0000});
    sbq.push_back(exp_t'{clockVal: 16'h0001, alarm: 1'b0, active: 4'b0000});
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      waitMinute(cy, to);
      nChecks++;
      if (to || cy != TPM || Clock !== e.clockVal || Alarm !== e.alarm || min_tick !== 1'b1) begin
        nErrors++;
        $display("[TB] FAIL rollover: got clock=%h cycles=%0d tick=%b alarm=%b, expected clock=%h cycles=%0d tick=1 alarm=%b",
                 Clock, cy, min_tick, Alarm, e.clockVal, TPM, e.alarm);
      end
    end
    tick();
    nChecks++;
    if (min_tick !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL tick_width: got tick=%b, expected 0", min_tick);
    end
    loadClock(16'h2460);
    nChecks++;
    if (Clock !== 16'h0001) begin
      nErrors++;
      $display("[TB] FAIL invalid_load: got clock=%h, expected 0001", Clock);
    end
  endtask

  task automatic test_snooze();
    exp_t e;
    int cy;
    bit to;
    logic a;
    writeAlarm(1, 1'b1, 14'h0600, 4'd3);
    loadClock(16'h0559);
    for (int n = 0; n <= 10; n++) begin
      a = (n <= 1) || (n >= 6 && n <= 8);
      sbq.push_back(exp_t'{clockVal: bcdAdd(16'h0600, n), alarm: a, active: {2'b00, a, 1'b0}});
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      waitMinute(cy, to);
      nChecks++;
      if (to || Clock !== e.clockVal || Alarm !== e.alarm || alarm_active !== e.active) begin
        nErrors++;
        $display("[TB] FAIL snooze_seq: got clock=%h alarm=%b active=%b timeout=%0b, expected clock=%h alarm=%b active=%b",
                 Clock, Alarm, alarm_active, to, e.clockVal, e.alarm, e.active);
      end
      if (e.clockVal == 16'h0601) begin
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        nChecks++;
        if (Alarm !== 1'b0 || alarm_active !== 4'b0000) begin
          nErrors++;
          $display("[TB] FAIL snooze_enter: got alarm=%b active=%b, expected 0/0000", Alarm, alarm_active);
        end
      end
    end
    writeAlarm(1, 1'b0, 14'h0000, 4'd0);
  endtask

  task automatic test_ring_forever();
    exp_t e;
    int cy;
    bit to;
    bit found;
    writeAlarm(2, 1'b1, 14'h0700, 4'd0);
    loadClock(16'h0659);
    for (int n = 0; n <= 10; n++) begin
      sbq.push_back(exp_t'{clockVal: bcdAdd(16'h0700, n), alarm: 1'b1, active: 4'b0100});
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      waitMinute(cy, to);
      nChecks++;
      if (to || Clock !== e.clockVal || Alarm !== e.alarm || alarm_active !== e.active) begin
        nErrors++;
        $display("[TB] FAIL forever_seq: got clock=%h alarm=%b active=%b timeout=%0b, expected clock=%h alarm=%b active=%b",
                 Clock, Alarm, alarm_active, to, e.clockVal, e.alarm, e.active);
      end
    end
    off_Alarm = 1'b1;
    tick();
    off_Alarm = 1'b0;
    nChecks++;
    if (Alarm !== 1'b0 || alarm_active !== 4'b0000) begin
      nErrors++;
      $display("[TB] FAIL dismiss: got alarm=%b active=%b, expected 0/0000", Alarm, alarm_active);
    end
    found = 1'b0;
    for (int k = 0; k < 14400 + 2 * TPM; k++) begin
      tick();
      if (Alarm === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    nChecks++;
    if (!found || Clock !== 16'h0700 || alarm_active !== 4'b0100) begin
      nErrors++;
      $display("[TB] FAIL next_day: got found=%0b clock=%h active=%b, expected found=1 clock=0700 active=0100",
               found, Clock, alarm_active);
    end
    writeAlarm(2, 1'b0, 14'h0000, 4'd0);
    nChecks++;
    if (Alarm !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL write_abort: got alarm=%b, expected 0", Alarm);
    end
  endtask

  task automatic test_multi_channel();
    exp_t e;
    int cy;
    bit to;
    writeAlarm(0, 1'b1, 14'h0800, 4'd2);
    writeAlarm(3, 1'b1, 14'h0801, 4'd2);
    loadClock(16'h0759);
    sbq.push_back(exp_t'{clockVal: 16'h0800, alarm: 1'b1, active: 4'b0001});
    sbq.push_back(exp_t'{clockVal: 16'h0801, alarm: 1'b1, active: 4'b1001});
    sbq.push_back(exp_t'{clockVal: 16'h0802, alarm: 1'b1, active: 4'b1000});
    sbq.push_back(exp_t'{clockVal: 16'h0803, alarm: 1'b0, active: 4'b0000});
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      waitMinute(cy, to);
      nChecks++;
      if (to || Clock !== e.clockVal || Alarm !== e.alarm || alarm_active !== e.active) begin
        nErrors++;
        $display("[TB] FAIL multi_seq: got clock=%h alarm=%b active=%b timeout=%0b, expected clock=%h alarm=%b active=%b",
                 Clock, Alarm, alarm_active, to, e.clockVal, e.alarm, e.active);
      end
    end
  endtask

  task automatic test_back_to_back();
    writeAlarm(0, 1'b1, 14'h0900, 4'd0);
    writeAlarm(3, 1'b1, 14'h0900, 4'd0);
    loadClock(16'h0900);
    nChecks++;
    if (Alarm !== 1'b1 || alarm_active !== 4'b1001) begin
      nErrors++;
      $display("[TB] FAIL load_match: got alarm=%b active=%b, expected 1/1001", Alarm, alarm_active);
    end
    // Same-cycle write to ch0 and global dismiss
    set_Alarm = {1'b1, 1'b1, 14'h1000};
    alarm_sel = 2'd0;
    dur_Alarm = 4'd0;
    off_Alarm = 1'b1;
    tick();
    set_Alarm = 16'h0000;
    off_Alarm = 1'b0;
    nChecks++;
    if (Alarm !== 1'b0 || alarm_active !== 4'b0000) begin
      nErrors++;
      $display("[TB] FAIL write_vs_off: got alarm=%b active=%b, expected 0/0000", Alarm, alarm_active);
    end
    loadClock(16'h1000);
    nChecks++;
    if (Alarm !== 1'b1 || alarm_active !== 4'b0001) begin
      nErrors++;
      $display("[TB] FAIL written_time: got alarm=%b active=%b, expected 1/0001", Alarm, alarm_active);
    end
    // Asynchronous reset in the middle of a cycle while ch0 rings
    #3;
    reset = 1'b1;
    #1;
    nChecks++;
    if (Clock !== 16'h0000 || Alarm !== 1'b0 || alarm_active !== 4'b0000 || min_tick !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL async_reset: got clock=%h alarm=%b active=%b tick=%b, expected 0000/0/0000/0",
               Clock, Alarm, alarm_active, min_tick);
    end
    tick();
    tick();
    reset = 1'b0;
    loadClock(16'h1000);
    nChecks++;
    if (Clock !== 16'h1000 || Alarm !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL post_reset_idle: got clock=%h alarm=%b, expected 1000/0", Clock, Alarm);
    end
  endtask

  // Scenario sequencer
  initial begin
    reset     = 1'b1;
    set_Clock = 16'h0000;
    set_Alarm = 16'h0000;
    alarm_sel = '0;
    dur_Alarm = '0;
    off_Alarm = 1'b0;
    snooze    = 1'b0;
    test_reset();
    test_single_ring();
    test_rollover();
    test_snooze();
    test_ring_forever();
    test_multi_channel();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/multi_alarm_clock.md
Name: multi_alarm_clock

Overview:
Parametrised successor to the single-alarm clock. Keeps a BCD HH:MM 24-hour time-of-day counter and supports NUM_ALARMS independent alarm channels. Each channel has a per-channel duration, daily re-arm, snooze and dismiss. Sits between the front-panel register interface and the buzzer/indicator drivers.

Parameters:
TICKS_PER_MIN, 60000, clk cycles per minute (1 ms clk gives 60000)
NUM_ALARMS, 4, number of alarm channels (1..16)
SEL_W, 2, width of alarm_sel; must be >= clog2(NUM_ALARMS)
DUR_W, 4, width of duration field in minutes
SNOOZE_MIN, 5, snooze length in minutes (1..2^DUR_W-1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
set_Clock  in  16  BCD HH:MM time load; any nonzero valid value loads
set_Alarm  in  16  [15]=write strobe, [14]=arm(1)/disarm(0), [13:0]=BCD HH:MM alarm time
alarm_sel  in  SEL_W  channel addressed by a set_Alarm write
dur_Alarm  in  DUR_W  ring duration in minutes, captured on write; 0 = ring until dismissed
off_Alarm  in  1  dismiss all ringing/snoozed channels
snooze  in  1  snooze all ringing channels
Clock  out  16  current time, BCD HH:MM
Alarm  out  1  OR of all channels in RINGING
alarm_active  out  NUM_ALARMS  per-channel RINGING flag
min_tick  out  1  one-cycle pulse on each minute rollover

Behaviour:
- Reset (async) clears everything: Clock=16'h0000, tick counter=0, all channels IDLE with time 00:00 and duration 0. Alarm, alarm_active and min_tick are all 0.
- Tick counter runs 0..TICKS_PER_MIN-1. At the terminal count it wraps to 0, pulses min_tick and increments Clock in BCD. Minutes roll 59->00 with hour carry; hours roll 23->00. 23:59 becomes 00:00.
- Clock load: when set_Clock != 0 and the value is valid BCD (hours 00-23, minutes 00-59), Clock takes it on the next edge and the tick counter clears. No min_tick is pulsed that cycle. A load has priority over the increment. Invalid values are ignored. 00:00 is only reachable by reset or rollover.
- Time event = cycle in which Clock changes, by rollover or by load. Matching uses the next-Clock value, so a channel enters RINGING on the same edge at which Clock shows its alarm time.
- Per-channel FSM, states IDLE / ARMED / RINGING / SNOOZED:
  IDLE: no matching.
  ARMED -> RINGING on a time event whose new time equals the channel time; rem loads from dur.
  RINGING: rem decrements on each min_tick. When dur != 0 and rem reaches 0 -> ARMED. dur = 0 rings until off_Alarm.
  RINGING + snooze -> SNOOZED, with snz = SNOOZE_MIN.
  SNOOZED: snz decrements on each min_tick. At 0 -> RINGING with rem reloaded from dur.
  RINGING/SNOOZED + off_Alarm -> ARMED.
  off_Alarm beats snooze.
- After a ring ends the channel stays ARMED, so it re-rings at the same time the next day.
- Write (set_Alarm[15]=1): the selected channel stores time [13:0] and dur_Alarm. State becomes ARMED if [14]=1, IDLE if [14]=0, aborting any ring or snooze. An invalid-BCD time forces IDLE. alarm_sel >= NUM_ALARMS is ignored.
- A write to a channel wins over off/snooze/match for that channel in the same cycle. Other channels are unaffected.
- Multiple channels may ring at once. Alarm stays high until all channels leave RINGING.
- Loading Clock during a ring does not stop it. The next ring minute is counted from the load.
- Alarm and alarm_active are registered state decodes; no combinational path from inputs.

Test Plan:
(All tests with TICKS_PER_MIN=10.)
1. Reset, load 12:32, write ch0 13:08 armed dur 8 -> Alarm rises exactly when Clock=16'h1308; falls when Clock=16'h1316; ch0 back to ARMED.
2. Load 23:58 -> min_tick every 10 cycles; Clock goes 23:59 then 00:00, then 00:01. Load 16'h2460 -> ignored, Clock unchanged.
3. ch1 06:00 dur 3, snooze pulse at 06:01 -> Alarm low 06:01-06:05; re-rises at 06:06; falls at 06:09.
4. ch2 07:00 dur 0, off_Alarm at 07:10 -> Alarm falls the next edge. Run 14400 more cycles -> Alarm rises again at 07:00 the next day.
5. ch0 08:00 dur 2 and ch3 08:01 dur 2 -> alarm_active 4'b0001 at 08:00, 4'b1001 at 08:01, 4'b1000 at 08:02, 0 at 08:03. Alarm is high 08:00-08:02.
6. Async reset asserted mid-ring, plus a same-cycle write and off on ch0 -> reset zeros all outputs immediately. The write-vs-off cycle leaves ch0 in the written state (ARMED).
